// File: rtl/uart_pkg.sv
// ASCII constants, parser state encoding and byte classifiers for ascii_number_parser.
package uart_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_NINE  = 8'h39;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_COMMA = 8'h2C;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;

  typedef enum logic {
    IDLE = 1'b0,
    NUM  = 1'b1
  } parser_state_e;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
  endfunction

  function automatic logic is_eol(input logic [7:0] b);
    return (b == ASCII_LF) || (b == ASCII_CR);
  endfunction

  function automatic logic is_delim(input logic [7:0] b);
    return is_eol(b) || (b == ASCII_COMMA) || (b == ASCII_SPACE);
  endfunction

endpackage

// File: rtl/parser_fifo.sv
// Small synchronous FIFO: push/full on the write side, valid/ready on the read side.
module parser_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full      = (cnt_q == CNT_W'(DEPTH));
  assign pop_valid = (cnt_q != '0);
  assign pop_data  = mem_q[rd_ptr_q];
  assign do_pop    = pop_valid && pop_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push   = push && (!full || do_pop);

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Storage is reset too so the head reads zero while reset is held.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/ascii_number_parser.sv
// Parses decimal ASCII tokens from a byte stream into unsigned values queued in a FIFO.
// Optional macro ASCII_NUMBER_PARSER_NEG_EN enables a leading '-' for two's-complement output.
module ascii_number_parser
  import uart_pkg::*;
#(
  parameter int unsigned VAL_W      = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rx_strobe,
  input  logic [7:0]       rx_byte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VAL_W-1:0] out_value,
  output logic             out_eol,
  output logic             out_sat,
  output logic             drop_err,
  output logic             char_err
);

  localparam int unsigned EXT_W  = VAL_W + 4;
  localparam int unsigned FIFO_W = VAL_W + 2;

  parser_state_e    state_q, state_d;
  logic [VAL_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;
  logic             char_err_q, char_err_d;
  logic             drop_err_q, drop_err_d;
`ifdef ASCII_NUMBER_PARSER_NEG_EN
  logic             neg_q, neg_d;
`endif

  logic [3:0]        digit_c;
  logic [EXT_W-1:0]  acc_ext_c;
  logic              ovf_c;
  logic              push_c;
  logic              push_eol_c;
  logic [VAL_W-1:0]  push_value_c;
  logic [FIFO_W-1:0] push_data_c;
  logic [FIFO_W-1:0] pop_data_c;
  logic              fifo_full_c;

  assign digit_c   = 4'(rx_byte - ASCII_ZERO);
  assign acc_ext_c = EXT_W'(acc_q) * EXT_W'(4'd10) + EXT_W'(digit_c);
  assign ovf_c     = |acc_ext_c[EXT_W-1:VAL_W];

  // Token FSM: advances only on strobed bytes.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    sat_d      = sat_q;
    char_err_d = 1'b0;
    push_c     = 1'b0;
    push_eol_c = 1'b0;
`ifdef ASCII_NUMBER_PARSER_NEG_EN
    neg_d      = neg_q;
`endif
    if (rx_strobe) begin
      if (is_digit(rx_byte)) begin
        if (state_q == IDLE) begin
          state_d = NUM;
          acc_d   = VAL_W'(digit_c);
          sat_d   = 1'b0;
        end else if (sat_q || ovf_c) begin
          acc_d = '1;
          sat_d = 1'b1;
        end else begin
          acc_d = acc_ext_c[VAL_W-1:0];
        end
      end else if (is_delim(rx_byte)) begin
        if (state_q == NUM) begin
          push_c     = 1'b1;
          push_eol_c = is_eol(rx_byte);
          state_d    = IDLE;
          acc_d      = '0;
          sat_d      = 1'b0;
`ifdef ASCII_NUMBER_PARSER_NEG_EN
          neg_d      = 1'b0;
`endif
        end
`ifdef ASCII_NUMBER_PARSER_NEG_EN
      end else if ((rx_byte == ASCII_MINUS) && (state_q == IDLE)) begin
        neg_d = 1'b1;
`endif
      end else begin
        char_err_d = 1'b1;
        state_d    = IDLE;
        acc_d      = '0;
        sat_d      = 1'b0;
`ifdef ASCII_NUMBER_PARSER_NEG_EN
        neg_d      = 1'b0;
`endif
      end
    end
  end

  // Value pushed into the FIFO, negated when a leading minus was seen.
  always_comb begin
`ifdef ASCII_NUMBER_PARSER_NEG_EN
    if (neg_q) begin
      push_value_c = sat_q ? {1'b1, {(VAL_W-1){1'b0}}} : (~acc_q + VAL_W'(1));
    end else begin
      push_value_c = acc_q;
    end
`else
    push_value_c = acc_q;
`endif
  end

  assign push_data_c = {push_value_c, push_eol_c, sat_q};

  // Sticky drop flag: set when a completed number finds the FIFO full and not draining.
  always_comb begin
    drop_err_d = drop_err_q;
    if (push_c && fifo_full_c && !(out_valid && out_ready)) begin
      drop_err_d = 1'b1;
    end
  end

  // Parser state and error flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      sat_q      <= 1'b0;
      char_err_q <= 1'b0;
      drop_err_q <= 1'b0;
`ifdef ASCII_NUMBER_PARSER_NEG_EN
      neg_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      sat_q      <= sat_d;
      char_err_q <= char_err_d;
      drop_err_q <= drop_err_d;
`ifdef ASCII_NUMBER_PARSER_NEG_EN
      neg_q      <= neg_d;
`endif
    end
  end

  parser_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_c),
    .push_data (push_data_c),
    .full      (fifo_full_c),
    .pop_valid (out_valid),
    .pop_ready (out_ready),
    .pop_data  (pop_data_c)
  );

  assign out_value = pop_data_c[FIFO_W-1:2];
  assign out_eol   = pop_data_c[1];
  assign out_sat   = pop_data_c[0];
  assign char_err  = char_err_q;
  assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_ascii_number_parser.sv
// Self-checking bench for ascii_number_parser: token-level model plus directed scenarios.
module tb_ascii_number_parser;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] v;
    logic        e;
    logic        s;
  } ent_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        rx_strobe;
  logic [7:0]  rx_byte;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_value;
  logic        out_eol;
  logic        out_sat;
  logic        drop_err;
  logic        char_err;

  int checks = 0;
  int errors = 0;

  ent_t m_q[$];
  int   m_dig[$];
  bit   m_neg;
  bit   m_drop;
  bit   m_cerr;

  ent_t seen[$];
  int   cerr_cnt = 0;

  ascii_number_parser #(.VAL_W(32), .FIFO_DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .rx_strobe (rx_strobe),
    .rx_byte   (rx_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_eol   (out_eol),
    .out_sat   (out_sat),
    .drop_err  (drop_err),
    .char_err  (char_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Token-level model: digits collected per token, value computed on the delimiter.
  task automatic model_byte(input logic [7:0] b);
    longint unsigned v;
    bit   s;
    ent_t e;
    if (b >= 8'h30 && b <= 8'h39) begin
      m_dig.push_back(int'(b) - 48);
    end else if (b == 8'h0A || b == 8'h0D || b == 8'h2C || b == 8'h20) begin
      if (m_dig.size() != 0) begin
        v = 0;
        s = 1'b0;
        foreach (m_dig[i]) begin
          if (!s) begin
            v = v * 10 + longint'(m_dig[i]);
            if (v > 64'hFFFF_FFFF) s = 1'b1;
          end
        end
        e.v = s ? 32'hFFFF_FFFF : v[31:0];
        if (m_neg) e.v = s ? 32'h8000_0000 : (32'h0 - v[31:0]);
        e.e = (b == 8'h0A || b == 8'h0D);
        e.s = s;
        if (m_q.size() >= DEPTH) m_drop = 1'b1;
        else m_q.push_back(e);
        m_dig.delete();
        m_neg = 1'b0;
      end
`ifdef ASCII_NUMBER_PARSER_NEG_EN
    end else if (b == 8'h2D && m_dig.size() == 0) begin
      m_neg = 1'b1;
`endif
    end else begin
      m_cerr = 1'b1;
      m_dig.delete();
      m_neg = 1'b0;
    end
  endtask

  // Model update on every clock edge and on reset assertion.
  initial begin
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        m_q.delete();
        m_dig.delete();
        m_neg  = 1'b0;
        m_drop = 1'b0;
        m_cerr = 1'b0;
      end else begin
        m_cerr = 1'b0;
        if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
        if (rx_strobe) model_byte(rx_byte);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clock);
      chk("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        chk("out_value", 64'(out_value), 64'(m_q[0].v));
        chk("out_eol", 64'(out_eol), 64'(m_q[0].e));
        chk("out_sat", 64'(out_sat), 64'(m_q[0].s));
      end
      chk("char_err", 64'(char_err), 64'(m_cerr));
      chk("drop_err", 64'(drop_err), 64'(m_drop));
      if (!reset) begin
        chk("rst_value", 64'({out_value, out_eol, out_sat}), 64'h0);
      end
      if (out_valid && out_ready) seen.push_back('{out_value, out_eol, out_sat});
      if (char_err) cerr_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clock);
    #1;
    rx_strobe = 1'b1;
    rx_byte   = b;
    @(posedge clock);
    #1;
    rx_strobe = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #3;
    reset = 1'b0;
    #5;
    reset = 1'b1;
  endtask

  task automatic chk_seen(input string name, input int idx, input logic [31:0] v,
                          input logic e, input logic s);
    if (idx >= seen.size()) begin
      chk({name, "_present"}, 64'(seen.size()), 64'(idx + 1));
    end else begin
      chk({name, "_value"}, 64'(seen[idx].v), 64'(v));
      chk({name, "_eol"}, 64'(seen[idx].e), 64'(e));
      chk({name, "_sat"}, 64'(seen[idx].s), 64'(s));
    end
  endtask

  initial begin
    int base;
    int c0;
    reset     = 1'b0;
    rx_strobe = 1'b0;
    rx_byte   = 8'h00;
    out_ready = 1'b1;
    idle(3);
    chk("reset_valid", 64'(out_valid), 64'h0);
    chk("reset_value", 64'(out_value), 64'h0);
    chk("reset_drop", 64'(drop_err), 64'h0);
    chk("reset_cerr", 64'(char_err), 64'h0);
    reset = 1'b1;
    idle(2);

    // Two tokens, each visible one cycle after its delimiter.
    base = seen.size();
    send_str("12,");
    chk("lat_12_valid", 64'(out_valid), 64'h1);
    chk("lat_12_value", 64'(out_value), 64'd12);
    send_str("345\n");
    chk("lat_345_valid", 64'(out_valid), 64'h1);
    chk("lat_345_value", 64'(out_value), 64'd345);
    chk("lat_345_eol", 64'(out_eol), 64'h1);
    idle(3);
    chk_seen("tok12", base, 32'd12, 1'b0, 1'b0);
    chk_seen("tok345", base + 1, 32'd345, 1'b1, 1'b0);

    // Saturation boundary and ignored repeated delimiters.
    base = seen.size();
    send_str("4294967296 4294967295,0\r\n  ");
    idle(3);
    chk("sat_count", 64'(seen.size() - base), 64'd3);
    chk_seen("over", base, 32'hFFFF_FFFF, 1'b0, 1'b1);
    chk_seen("max", base + 1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk_seen("zero", base + 2, 32'd0, 1'b1, 1'b0);

    // FIFO overflow with the consumer stalled, then drain.
    do_reset();
    out_ready = 1'b0;
    base = seen.size();
    send_str("1 2 3 4 5 ");
    idle(1);
    chk("ovf_drop", 64'(drop_err), 64'h1);
    chk("ovf_head", 64'(out_value), 64'd1);
    out_ready = 1'b1;
    idle(6);
    chk("ovf_count", 64'(seen.size() - base), 64'd4);
    for (int i = 0; i < 4; i++) chk_seen("drain", base + i, 32'(i + 1), 1'b0, 1'b0);
    chk("drop_sticky", 64'(drop_err), 64'h1);

    // Push into a full FIFO together with a pop succeeds.
    do_reset();
    out_ready = 1'b0;
    base = seen.size();
    send_str("1 2 3 4 5");
    @(posedge clock);
    #1;
    rx_strobe = 1'b1;
    rx_byte   = 8'h20;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    rx_strobe = 1'b0;
    out_ready = 1'b0;
    chk("fullpop_drop", 64'(drop_err), 64'h0);
    out_ready = 1'b1;
    idle(6);
    chk("fullpop_count", 64'(seen.size() - base), 64'd5);
    for (int i = 0; i < 5; i++) chk_seen("fullpop", base + i, 32'(i + 1), 1'b0, 1'b0);

    // Illegal byte discards the partial token.
    base = seen.size();
    c0   = cerr_cnt;
    send_str("7x8\n");
    idle(3);
    chk("illegal_pulses", 64'(cerr_cnt - c0), 64'd1);
    chk("illegal_count", 64'(seen.size() - base), 64'd1);
    chk_seen("illegal", base, 32'd8, 1'b1, 1'b0);

    // Reset mid-token discards it.
    base = seen.size();
    send_str("99");
    do_reset();
    send_str("5\n");
    idle(3);
    chk("midrst_count", 64'(seen.size() - base), 64'd1);
    chk_seen("midrst", base, 32'd5, 1'b1, 1'b0);

    // Leading minus.
    base = seen.size();
    c0   = cerr_cnt;
    send_str("-42\n");
    idle(3);
    chk("neg_count", 64'(seen.size() - base), 64'd1);
`ifdef ASCII_NUMBER_PARSER_NEG_EN
    chk("neg_pulses", 64'(cerr_cnt - c0), 64'd0);
    chk_seen("neg", base, 32'hFFFF_FFD6, 1'b1, 1'b0);
`else
    chk("neg_pulses", 64'(cerr_cnt - c0), 64'd1);
    chk_seen("neg", base, 32'd42, 1'b1, 1'b0);
`endif

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ascii_number_parser.md
ASCII_NUMBER_PARSER -- requirements
Module: ascii_number_parser

Interface
REQ-001 SHALL have parameter VAL_W, default 32: width of the parsed unsigned value.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: output FIFO entries, a power of two of at least 2.
REQ-003 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset (asserted when 0).
REQ-005 SHALL have port rx_strobe, input, 1, one-cycle pulse marking rx_byte valid; cannot be back-pressured.
REQ-006 SHALL have port rx_byte, input, 8, received ASCII byte; sampled only when rx_strobe=1.
REQ-007 SHALL have port out_valid, output, 1, FIFO head holds a parsed number.
REQ-008 SHALL have port out_ready, input, 1, consumer accepts head when out_valid and out_ready are both 1.
REQ-009 SHALL have port out_value, output, VAL_W, parsed value at FIFO head.
REQ-010 SHALL have port out_eol, output, 1, head number was terminated by 0x0A or 0x0D.
REQ-011 SHALL have port out_sat, output, 1, head number saturated during accumulation.
REQ-012 SHALL have port drop_err, output, 1, sticky: a completed number was lost because the FIFO was full.
REQ-013 SHALL have port char_err, output, 1, one-cycle pulse on each illegal byte.

Function
REQ-014 SHALL run an FSM with states IDLE (no digits yet) and NUM (at least one digit seen); it advances only on cycles with rx_strobe=1.
REQ-015 Digit 0x30-0x39: IDLE goes to NUM with acc=d; NUM sets acc=acc*10+d.
REQ-016 If acc*10+d exceeds 2^VAL_W-1, acc SHALL saturate to all-ones and set sat; saturation SHALL hold for the rest of the token.
REQ-017 Delimiter 0x0A, 0x0D, 0x2C or 0x20 in NUM SHALL push {acc, eol, sat} into the FIFO, clear acc and sat, and return to IDLE.
REQ-018 A delimiter in IDLE SHALL be ignored with no push, so "\r\n" and repeated spaces produce nothing.
REQ-019 Any other byte SHALL pulse char_err the next cycle, discard the partial token, and go to IDLE.
REQ-020 Latency: with the FIFO empty, a delimiter strobe in cycle N SHALL give out_valid=1 in cycle N+1.
REQ-021 A push while the FIFO is full with no simultaneous pop SHALL drop the new entry and set drop_err.
REQ-022 A push while full with a simultaneous pop SHALL succeed.
REQ-023 A simultaneous push and pop on an empty FIFO is impossible, because out_valid=0.
REQ-024 out_value, out_eol and out_sat SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL use a log2(FIFO_DEPTH)+1-bit count.

Reset
REQ-026 reset=0 SHALL immediately clear FSM to IDLE, acc, sat, neg, FIFO pointers and count, out_valid, drop_err and char_err, regardless of clock.
REQ-027 out_value, out_eol and out_sat SHALL read 0 during reset.
REQ-028 Reset mid-token SHALL discard the token; the first byte after release is parsed from IDLE.
REQ-029 drop_err SHALL clear only on reset.

Configuration
REQ-030 With macro ASCII_NUMBER_PARSER_NEG_EN defined, 0x2D in IDLE SHALL set neg and stay in IDLE.
REQ-031 With NEG_EN defined, a push SHALL emit two's-complement -acc when neg=1, and a saturated negative value SHALL be -(2^(VAL_W-1)).
REQ-032 With NEG_EN defined, 0x2D in NUM SHALL be illegal per REQ-019.
REQ-033 Without the macro, 0x2D SHALL always be illegal and no neg register SHALL exist.

Structure
REQ-034 Package uart_pkg SHALL hold the ASCII constants (digit range, LF, CR, comma, space, minus) and the parser state enum.
REQ-035 The FIFO SHALL be sub-module parser_fifo, parameterised by width and depth, with push/full and valid/ready pop.

Verification
REQ-036 Bytes "12,345\n" with out_ready=1 SHALL give 12 (eol=0), then 345 (eol=1), each one cycle after its delimiter strobe.
REQ-037 "4294967296 " SHALL give out_value=0xFFFFFFFF with out_sat=1.
REQ-038 With out_ready=0, "1 2 3 4 5 " SHALL leave FIFO 1,2,3,4, set drop_err=1, and drain 1,2,3,4 in order once out_ready=1.
REQ-039 "7x8\n" SHALL pulse char_err once and emit only 8 with eol=1.
REQ-040 Asserting reset after "99" then sending "5\n" SHALL emit 5 only.
REQ-041 With NEG_EN defined, "-42\n" SHALL emit 0xFFFFFFD6; without it, "-42\n" SHALL pulse char_err and emit 42.
